nash_stream_array: RTL

//  Multi-lane, flow-controlled Nash cipher stream stage. LANES independent nash_core

---
 rtl/nash_pkg.sv | 18 +
 rtl/nash_core.sv | 84 ++++++++
 rtl/nash_sync_fifo.sv | 56 +++++
 rtl/nash_stream_array.sv | 125 ++++++++++++
 4 files changed

// File: rtl/nash_pkg.sv
// Shared types and sizing helpers for the Nash stream array.
package nash_pkg;

  typedef enum logic [1:0] {
    S_CFG   = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } nash_state_e;

  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nash_core.sv
// One-bit Nash cipher lane: ciphertext selects the red or blue permutation that
// advances the key state; registered output, one cycle latency.
module nash_core #(
  parameter int STATE_WIDTH = 4,
  parameter int MEM_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 config_valid,
  output logic                 config_ready,
  input  logic [MEM_DEPTH-1:0] red_perm,
  input  logic [MEM_DEPTH-1:0] red_inv,
  input  logic [MEM_DEPTH-1:0] blue_perm,
  input  logic [MEM_DEPTH-1:0] blue_inv,
  input  logic                 valid_in,
  input  logic                 data_in,
  output logic                 valid_out,
  output logic                 data_out
);
  localparam int SEL_W = (STATE_WIDTH > 1) ? $clog2(STATE_WIDTH) : 1;

  logic [MEM_DEPTH-1:0]   rp_q, rp_d, ri_q, ri_d, bp_q, bp_d, bi_q, bi_d;
  logic [MEM_DEPTH-1:0]   perm, inv;
  logic [STATE_WIDTH-1:0] s_q, s_d, inv_eff;
  logic [SEL_W-1:0]       sel;
  logic                   c, vout_q, vout_d, dout_q, dout_d;

  always_comb begin
    rp_d    = rp_q;
    ri_d    = ri_q;
    bp_d    = bp_q;
    bi_d    = bi_q;
    s_d     = s_q;
    vout_d  = 1'b0;
    dout_d  = dout_q;
    sel     = '0;
    c       = data_in ^ s_q[0];
    perm    = c ? bp_q : rp_q;
    inv     = c ? bi_q : ri_q;
    // The invert mask is wider than the state; it folds onto it by XOR.
    inv_eff = '0;
    for (int j = 0; j < MEM_DEPTH; j++) inv_eff[j % STATE_WIDTH] ^= inv[j];
    if (config_valid) begin
      rp_d = red_perm;
      ri_d = red_inv;
      bp_d = blue_perm;
      bi_d = blue_inv;
      s_d  = '0;
    end else if (valid_in) begin
      for (int i = 0; i < STATE_WIDTH; i++) begin
        sel    = perm[i*SEL_W +: SEL_W];
        s_d[i] = s_q[sel] ^ inv_eff[i];
      end
      s_d[0] = s_d[0] ^ c;
      vout_d = 1'b1;
      dout_d = c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_q   <= '0;
      ri_q   <= '0;
      bp_q   <= '0;
      bi_q   <= '0;
      s_q    <= '0;
      vout_q <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      rp_q   <= rp_d;
      ri_q   <= ri_d;
      bp_q   <= bp_d;
      bi_q   <= bi_d;
      s_q    <= s_d;
      vout_q <= vout_d;
      dout_q <= dout_d;
    end
  end

  assign config_ready = !vout_q;
  assign valid_out    = vout_q;
  assign data_out     = dout_q;

endmodule

// File: rtl/nash_sync_fifo.sv
// Register-based synchronous FIFO with a combinational head; caller guarantees
// no overflow and no pop when empty.
module nash_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/nash_stream_array.sv
// Multi-lane Nash cipher stage with retarded-plaintext whitening, credit-based
// valid/ready flow control and a drain-before-reconfigure FSM.
module nash_stream_array import nash_pkg::*; #(
  parameter  int STATE_WIDTH = 4,
  parameter  int MEM_DEPTH   = 8,
  parameter  int LANES       = 4,
  parameter  int DELAY       = 1,
  parameter  int FIFO_DEPTH  = 4,
  localparam int LANE_W      = lane_w(LANES),
  localparam int FILL_W      = cnt_w(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LANES-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [LANES-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [LANE_W-1:0]    cfg_lane,
  input  logic [MEM_DEPTH-1:0] cfg_red_perm,
  input  logic [MEM_DEPTH-1:0] cfg_red_inv,
  input  logic [MEM_DEPTH-1:0] cfg_blue_perm,
  input  logic [MEM_DEPTH-1:0] cfg_blue_inv,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [LANES-1:0]     cfg_loaded,
  output logic [1:0]           dbg_fsm,
  output logic [FILL_W-1:0]    dbg_fill
);
  nash_state_e      state_q, state_d;
  logic [LANES-1:0] cfg_loaded_q, cfg_loaded_d;
  logic [LANES-1:0] ret_q [DELAY];
  logic [LANES-1:0] ret_d [DELAY];
  logic [LANES-1:0] lane_hit, core_cfg_ready, core_cfg_valid, core_vout, core_dout;
  logic [LANES-1:0] tap_head;
  logic [FILL_W-1:0] fifo_count, tap_count, fill;
  logic             in_fire, cfg_fire, done;

  // The tap queue holds one entry per beat inside the cores, so its count is the in-flight count.
  assign fill      = fifo_count + tap_count;
  assign in_ready  = (state_q == S_RUN) && (fill < FILL_W'(FIFO_DEPTH));
  assign cfg_ready = (state_q == S_CFG) && (!(|lane_hit) || |(lane_hit & core_cfg_ready));
  assign in_fire   = in_valid && in_ready;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign done      = core_vout[0];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_hit[i]       = (cfg_lane == LANE_W'(i));
    assign core_cfg_valid[i] = cfg_fire && lane_hit[i];
    nash_core #(.STATE_WIDTH(STATE_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_core (
      .clk          (clk),
      .rst_n        (rst_n),
      .config_valid (core_cfg_valid[i]),
      .config_ready (core_cfg_ready[i]),
      .red_perm     (cfg_red_perm),
      .red_inv      (cfg_red_inv),
      .blue_perm    (cfg_blue_perm),
      .blue_inv     (cfg_blue_inv),
      .valid_in     (in_fire),
      .data_in      (in_data[i]),
      .valid_out    (core_vout[i]),
      .data_out     (core_dout[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    cfg_loaded_d = cfg_loaded_q;
    ret_d        = ret_q;
    if (in_fire) begin
      ret_d[0] = in_data;
      for (int k = 1; k < DELAY; k++) ret_d[k] = ret_q[k-1];
    end
    if (cfg_fire) cfg_loaded_d = cfg_loaded_q | lane_hit;
    case (state_q)
      S_CFG:   if (&cfg_loaded_q && !cfg_valid) state_d = S_RUN;
      S_RUN:   if (cfg_valid) state_d = S_DRAIN;
      S_DRAIN: if (tap_count == '0 && fifo_count == '0) begin
        state_d = S_CFG;
        for (int k = 0; k < DELAY; k++) ret_d[k] = '0;
      end
      default: state_d = S_CFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CFG;
      cfg_loaded_q <= '0;
      for (int k = 0; k < DELAY; k++) ret_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      cfg_loaded_q <= cfg_loaded_d;
      ret_q        <= ret_d;
    end
  end

  nash_sync_fifo #(.WIDTH(LANES), .DEPTH(FIFO_DEPTH)) u_tap_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_fire),
    .push_data (ret_q[DELAY-1]),
    .pop       (done),
    .head      (tap_head),
    .count     (tap_count)
  );

  // Lanes finish in lockstep; masking by each lane's valid keeps every valid bit in the path.
  nash_sync_fifo #(.WIDTH(LANES), .DEPTH(FIFO_DEPTH)) u_out_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (done),
    .push_data ((core_dout & core_vout) ^ tap_head),
    .pop       (out_valid && out_ready),
    .head      (out_data),
    .count     (fifo_count)
  );

  assign out_valid  = (fifo_count != '0);
  assign cfg_loaded = cfg_loaded_q;
  assign dbg_fsm    = state_q;
  assign dbg_fill   = fill;

endmodule
